mac_pe_param: RTL

Parametrised processing element for the systolic array: a registered multiply-accumulate cell that forwards its A/B operands to neighbouring cells and adds their product into a local accumulator. It adds the following over the fixed 8-bit cell:
- generic operand and accumulator widths;
- per-beat signed/unsigned mode;
- valid-qualified accumulation with explicit clear;
- optional saturation with a sticky overflow flag;
- a result shift chain for draining accumulators out of an array column.

---
 rtl/mac_pe_param_if.sv | 35 +++
 rtl/mac_pe_param.sv | 73 +++++++
 2 files changed

// File: rtl/mac_pe_param_if.sv
// Per-cell bus for mac_pe_param: operand beat, accumulator controls and result chain.
// slave = the PE itself; master = whatever drives the cell (array fabric or bench).
interface mac_pe_param_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic              in_valid;
  logic              in_signed;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              acc_clear;
  logic              drain;
  logic              shift_en;
  logic [ACC_W-1:0]  result_in;
  logic              result_in_valid;
  logic              out_valid;
  logic              out_signed;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [ACC_W-1:0]  result_out;
  logic              result_out_valid;
  logic              acc_ovf;

  modport slave (
    input  in_valid, in_signed, in_a, in_b, acc_clear, drain, shift_en,
           result_in, result_in_valid,
    output out_valid, out_signed, out_a, out_b, result_out, result_out_valid, acc_ovf
  );

  modport master (
    output in_valid, in_signed, in_a, in_b, acc_clear, drain, shift_en,
           result_in, result_in_valid,
    input  out_valid, out_signed, out_a, out_b, result_out, result_out_valid, acc_ovf
  );
endinterface

// File: rtl/mac_pe_param.sv
// Parametrised systolic MAC cell: forwards operands, accumulates signed/unsigned products
// with optional saturation, and drains its accumulator into a per-column result shift chain.
module mac_pe_param #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic          clk,
  input  logic          reset,
  mac_pe_param_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W:0]   prod_ext, base_ext, sum;
  logic             ovf;
  logic [ACC_W-1:0] acc_next;

  // Extending both operands to 2*DATA_W first makes the low half of the product
  // correct for either signedness.
  always_comb begin
    a_ext = {{DATA_W{bus.in_signed & bus.in_a[DATA_W-1]}}, bus.in_a};
    b_ext = {{DATA_W{bus.in_signed & bus.in_b[DATA_W-1]}}, bus.in_b};
    prod  = a_ext * b_ext;
    prod_ext = {{(ACC_W+1-PW){bus.in_signed & prod[PW-1]}}, prod};
    base_ext = bus.acc_clear ? '0 : {acc[ACC_W-1], acc};
    sum = base_ext + (bus.in_valid ? prod_ext : '0);
    ovf = sum[ACC_W] ^ sum[ACC_W-1];
    if (SATURATE != 0 && ovf)
      acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      acc_next = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid        <= 1'b0;
      bus.out_signed       <= 1'b0;
      bus.out_a            <= '0;
      bus.out_b            <= '0;
      bus.result_out       <= '0;
      bus.result_out_valid <= 1'b0;
      bus.acc_ovf          <= 1'b0;
      acc                  <= '0;
    end else begin
      bus.out_valid  <= bus.in_valid;
      bus.out_signed <= bus.in_signed;
      bus.out_a      <= bus.in_a;
      bus.out_b      <= bus.in_b;

      if (bus.in_valid && ovf)
        bus.acc_ovf <= 1'b1;
      else if (bus.acc_clear || bus.drain)
        bus.acc_ovf <= 1'b0;

      // Drain takes the chain slot, so the current beat is folded into the drained value.
      if (bus.drain) begin
        bus.result_out       <= acc_next;
        bus.result_out_valid <= 1'b1;
        acc                  <= '0;
      end else begin
        acc <= acc_next;
        if (bus.shift_en) begin
          bus.result_out       <= bus.result_in;
          bus.result_out_valid <= bus.result_in_valid;
        end
      end
    end
  end
endmodule
